// File: rtl/dsp_sched_pkg.sv
// Shared widths, the operation record carried down the MAC pipeline, and the
// reference multiply-shift-add used by the datapath.
package dsp_sched_pkg;

    localparam int A_W   = 17;
    localparam int C_W   = 32;
    localparam int SHIFT = 17;
    localparam int ID_W  = 3;
    localparam int S_W   = 17;
    localparam int P_W   = 2 * A_W;

    typedef struct packed {
        logic [A_W-1:0]  a;
        logic [A_W-1:0]  b;
        logic [C_W-1:0]  c;
        logic [ID_W-1:0] id;
    } sched_op_t;

    // c + sext(((a*b) >> SHIFT)[16:0]), wrapping modulo 2^C_W.
    function automatic logic [C_W-1:0] mac_ref(input logic [A_W-1:0] a,
                                               input logic [A_W-1:0] b,
                                               input logic [C_W-1:0] c);
        logic [P_W-1:0] p;
        logic [S_W-1:0] s;
        p = P_W'(a) * P_W'(b);
        s = S_W'(p >> SHIFT);
        return c + {{(C_W-S_W){s[S_W-1]}}, s};
    endfunction

endpackage

// File: rtl/dsp_mac_scheduler_if.sv
// Request fan-in and single response channel of the shared MAC scheduler.
interface dsp_mac_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0]                    req_ready;
    logic [NUM_REQ*dsp_sched_pkg::A_W-1:0] req_a;
    logic [NUM_REQ*dsp_sched_pkg::A_W-1:0] req_b;
    logic [NUM_REQ*dsp_sched_pkg::C_W-1:0] req_c;
    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic [IDX_W-1:0]                      rsp_id;
    logic [dsp_sched_pkg::C_W-1:0]         rsp_data;
    logic                                  busy;

    modport master (
        output req_valid, req_a, req_b, req_c, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/dsp_mac_pipe.sv
// PIPE_DEPTH-stage multiply-shift-add datapath; every stage advances together on en.
// The MAC is evaluated at the input so the trailing registers retime into the DSP slice.
module dsp_mac_pipe
    import dsp_sched_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    input  sched_op_t       op,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [C_W-1:0]  out_data,
    output logic            busy
);

    logic [C_W-1:0]        mac_next;
    logic [PIPE_DEPTH-1:0] stage_valid;

    assign mac_next = mac_ref(op.a, op.b, op.c);

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            logic            valid_reg;
            logic [ID_W-1:0] id_reg;
            logic [C_W-1:0]  data_reg;
            logic            valid_in;
            logic [ID_W-1:0] id_in;
            logic [C_W-1:0]  data_in;

            if (gi == 0) begin : g_head
                assign valid_in = in_valid;
                assign id_in    = op.id;
                assign data_in  = mac_next;
            end else begin : g_tail
                assign valid_in = g_stage[gi-1].valid_reg;
                assign id_in    = g_stage[gi-1].id_reg;
                assign data_in  = g_stage[gi-1].data_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    id_reg    <= '0;
                    data_reg  <= '0;
                end else if (en) begin
                    valid_reg <= valid_in;
                    id_reg    <= id_in;
                    data_reg  <= data_in;
                end
            end

            assign stage_valid[gi] = valid_reg;
        end
    endgenerate

    assign out_valid = g_stage[PIPE_DEPTH-1].valid_reg;
    assign out_id    = g_stage[PIPE_DEPTH-1].id_reg;
    assign out_data  = g_stage[PIPE_DEPTH-1].data_reg;
    assign busy      = |stage_valid;

endmodule

// File: rtl/dsp_mac_scheduler.sv
// Round-robin arbiter issuing at most one tagged op per cycle into the shared MAC pipe;
// a stalled response freezes the whole pipe and blocks new grants.
module dsp_mac_scheduler
    import dsp_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int PIPE_DEPTH = 3
) (
    input logic                clk,
    input logic                rst_n,
    dsp_mac_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic               adv;
    logic               grant_found;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   last_reg;
    sched_op_t          issue_op;
    logic [ID_W-1:0]    out_id;

    assign adv = !bus.rsp_valid || bus.rsp_ready;

    // Scan last+1, last+2, ... so the most recent winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        grant       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_reg) + k) % NUM_REQ);
            if (!grant_found && adv && rst_n && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        issue_op    = '0;
        issue_op.a  = bus.req_a[int'(grant_idx)*A_W +: A_W];
        issue_op.b  = bus.req_b[int'(grant_idx)*A_W +: A_W];
        issue_op.c  = bus.req_c[int'(grant_idx)*C_W +: C_W];
        issue_op.id = ID_W'(grant_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= IDX_W'(NUM_REQ - 1);
        end else if (grant_found) begin
            last_reg <= grant_idx;
        end
    end

    dsp_mac_pipe #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (adv),
        .in_valid (grant_found),
        .op       (issue_op),
        .out_valid(bus.rsp_valid),
        .out_id   (out_id),
        .out_data (bus.rsp_data),
        .busy     (bus.busy)
    );

    assign bus.rsp_id    = IDX_W'(out_id);
    assign bus.req_ready = grant;

endmodule
